// File: rtl/fft_sample_store.sv
// rtl/fft_sample_store.sv - single-port sample RAM shared by the AXI bridge and the FFT core
// Optional FFT_STORE_BITREV_EN: bridge load writes land at bit-reversed addresses (DIT input order).
module fft_sample_store #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic [15:0]           i_SAMPLE_ram,
   input  logic [ADDR_WIDTH-1:0] i_SAMPLE_INDEX_ram,
   input  logic                  i_WRITE_ram,
   input  logic                  i_READ_ram,
   input  logic                  i_DATA_LOADED,
   output logic [DATA_WIDTH-1:0] o_DATA_FROM_RAM,
   output logic                  o_CALC_END,
   input  logic [ADDR_WIDTH-1:0] i_SAMPLES_NUMBER,
   input  logic [3:0]            i_LOG2N,
   output logic                  o_FFT_START,
   input  logic [ADDR_WIDTH-1:0] i_FFT_ADDR,
   input  logic                  i_FFT_WE,
   input  logic                  i_FFT_RE,
   input  logic [DATA_WIDTH-1:0] i_FFT_WDATA,
   output logic [DATA_WIDTH-1:0] o_FFT_RDATA,
   input  logic                  i_FFT_DONE,
   output logic                  o_ACCESS_ERR
);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_START,
      ST_COMPUTE,
      ST_UNLOAD
   } state_t;

   state_t state;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   logic                  br_in_range;
   logic                  fft_in_range;
   logic [ADDR_WIDTH-1:0] load_addr;
   logic                  br_wr_ok;
   logic                  br_rd_ok;
   logic                  br_rd_oor;
   logic                  fft_wr_ok;
   logic                  fft_rd_ok;
   logic                  fft_rd_oor;
   logic                  reject;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [ADDR_WIDTH-1:0] mem_raddr;

   // A frame of the full depth does not fit in i_SAMPLES_NUMBER, so zero stands for 2**ADDR_WIDTH.
   assign br_in_range  = (i_SAMPLES_NUMBER == '0) || (i_SAMPLE_INDEX_ram < i_SAMPLES_NUMBER);
   assign fft_in_range = (i_SAMPLES_NUMBER == '0) || (i_FFT_ADDR < i_SAMPLES_NUMBER);

`ifdef FFT_STORE_BITREV_EN
   function automatic logic [ADDR_WIDTH-1:0] bit_reverse(
      input logic [ADDR_WIDTH-1:0] idx,
      input logic [3:0]            n_bits
   );
      logic [ADDR_WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < ADDR_WIDTH; i++) begin
         for (int j = 0; j < ADDR_WIDTH; j++) begin
            if (i + j + 1 == int'(n_bits)) r[i] = idx[j];
         end
      end
      return r;
   endfunction

   assign load_addr = bit_reverse(i_SAMPLE_INDEX_ram, i_LOG2N);
`else
   logic unused_log2n;
   assign unused_log2n = ^i_LOG2N;
   assign load_addr    = i_SAMPLE_INDEX_ram;
`endif

   always_comb begin
      br_wr_ok   = 1'b0;
      br_rd_ok   = 1'b0;
      br_rd_oor  = 1'b0;
      fft_wr_ok  = 1'b0;
      fft_rd_ok  = 1'b0;
      fft_rd_oor = 1'b0;
      reject     = 1'b0;
      case (state)
         ST_LOAD: begin
            if (i_WRITE_ram) begin
               if (br_in_range) br_wr_ok = 1'b1;
               else             reject   = 1'b1;
            end
            if (i_READ_ram || i_FFT_WE || i_FFT_RE) reject = 1'b1;
         end
         ST_START: begin
            if (i_WRITE_ram || i_READ_ram || i_FFT_WE || i_FFT_RE) reject = 1'b1;
         end
         ST_COMPUTE: begin
            if (i_WRITE_ram || i_READ_ram) reject = 1'b1;
            if (i_FFT_WE) begin
               if (fft_in_range) fft_wr_ok = 1'b1;
               else              reject    = 1'b1;
            end else if (i_FFT_RE) begin
               if (fft_in_range) fft_rd_ok = 1'b1;
               else begin
                  reject     = 1'b1;
                  fft_rd_oor = 1'b1;
               end
            end
         end
         ST_UNLOAD: begin
            // The single port cannot serve a new-frame write and a read together; the write wins.
            if (i_WRITE_ram) begin
               if (br_in_range) br_wr_ok = 1'b1;
               else             reject   = 1'b1;
               if (i_READ_ram)  reject   = 1'b1;
            end else if (i_READ_ram) begin
               if (br_in_range) br_rd_ok = 1'b1;
               else begin
                  reject    = 1'b1;
                  br_rd_oor = 1'b1;
               end
            end
            if (i_FFT_WE || i_FFT_RE) reject = 1'b1;
         end
      endcase
   end

   assign mem_we    = i_rstn && (br_wr_ok || fft_wr_ok);
   assign mem_waddr = fft_wr_ok ? i_FFT_ADDR : load_addr;
   assign mem_wdata = fft_wr_ok ? i_FFT_WDATA : {i_SAMPLE_ram, {(DATA_WIDTH-16){1'b0}}};
   assign mem_raddr = (state == ST_COMPUTE) ? i_FFT_ADDR : i_SAMPLE_INDEX_ram;

   always_ff @(posedge i_clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state           <= ST_LOAD;
         o_CALC_END      <= 1'b0;
         o_FFT_START     <= 1'b0;
         o_ACCESS_ERR    <= 1'b0;
         o_DATA_FROM_RAM <= '0;
         o_FFT_RDATA     <= '0;
      end else begin
         o_ACCESS_ERR <= reject;
         if (br_rd_ok)       o_DATA_FROM_RAM <= mem[mem_raddr];
         else if (br_rd_oor) o_DATA_FROM_RAM <= '0;
         if (fft_rd_ok)       o_FFT_RDATA <= mem[mem_raddr];
         else if (fft_rd_oor) o_FFT_RDATA <= '0;
         case (state)
            ST_LOAD: begin
               if (br_wr_ok && i_DATA_LOADED) state <= ST_START;
            end
            // START spans two cycles so the core sees its pulse before it owns the port.
            ST_START: begin
               if (!o_FFT_START) begin
                  o_FFT_START <= 1'b1;
               end else begin
                  o_FFT_START <= 1'b0;
                  state       <= ST_COMPUTE;
               end
            end
            ST_COMPUTE: begin
               if (i_FFT_DONE) begin
                  state      <= ST_UNLOAD;
                  o_CALC_END <= 1'b1;
               end
            end
            ST_UNLOAD: begin
               if (br_wr_ok) begin
                  state      <= ST_LOAD;
                  o_CALC_END <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_sample_store.sv
// tb/tb_fft_sample_store.sv - scoreboard bench for fft_sample_store
// Honours FFT_STORE_BITREV_EN the same way as the design build.
module tb_fft_sample_store;

   localparam int AW = 12;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rstn;
   logic [15:0]   sample;
   logic [AW-1:0] idx;
   logic          wr;
   logic          rd;
   logic          loaded;
   logic [DW-1:0] br_data;
   logic          calc_end;
   logic [AW-1:0] n_samples;
   logic [3:0]    log2n;
   logic          fft_start;
   logic [AW-1:0] faddr;
   logic          fwe;
   logic          fre;
   logic [DW-1:0] fwdata;
   logic [DW-1:0] frdata;
   logic          fdone;
   logic          acc_err;

   always #5 clk = ~clk;

   fft_sample_store #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .i_clk             (clk),
      .i_rstn            (rstn),
      .i_SAMPLE_ram      (sample),
      .i_SAMPLE_INDEX_ram(idx),
      .i_WRITE_ram       (wr),
      .i_READ_ram        (rd),
      .i_DATA_LOADED     (loaded),
      .o_DATA_FROM_RAM   (br_data),
      .o_CALC_END        (calc_end),
      .i_SAMPLES_NUMBER  (n_samples),
      .i_LOG2N           (log2n),
      .o_FFT_START       (fft_start),
      .i_FFT_ADDR        (faddr),
      .i_FFT_WE          (fwe),
      .i_FFT_RE          (fre),
      .i_FFT_WDATA       (fwdata),
      .o_FFT_RDATA       (frdata),
      .i_FFT_DONE        (fdone),
      .o_ACCESS_ERR      (acc_err)
   );

   typedef struct packed {
      logic          err;
      logic          start;
      logic          calc;
      logic [DW-1:0] br;
      logic [DW-1:0] fft;
   } exp_t;

   typedef enum int {P_LOAD, P_START, P_COMPUTE, P_UNLOAD} phase_t;

   exp_t          exp_q[$];
   exp_t          cur;
   phase_t        phase;
   int            start_wait;
   logic [DW-1:0] model_mem [int];
   int            n_checks = 0;
   int            n_fail   = 0;

`ifdef FFT_STORE_BITREV_EN
   localparam logic [DW-1:0] EXP_A3 = 32'h0007_0000;
`else
   localparam logic [DW-1:0] EXP_A3 = 32'h0004_0000;
`endif

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic int load_index(input int i);
`ifdef FFT_STORE_BITREV_EN
      int r;
      r = 0;
      for (int k = 0; k < int'(log2n); k++) r = (r << 1) | ((i >> k) & 1);
      return r;
`else
      return i;
`endif
   endfunction

   // Predict the outputs that follow the coming clock edge from the inputs now applied.
   task automatic step();
      exp_t   e;
      phase_t ph;
      int     n;
      logic   br_ok;
      logic   core_ok;
      e       = cur;
      e.err   = 1'b0;
      e.start = 1'b0;
      ph      = phase;
      n       = int'(n_samples);
      if (n == 0) n = 1 << AW;
      br_ok   = int'(idx) < n;
      core_ok = int'(faddr) < n;
      if (!rstn) begin
         phase      = P_LOAD;
         start_wait = 0;
         e          = '0;
      end else begin
         if (rd) begin
            if (ph != P_UNLOAD) e.err = 1'b1;
            else if (!br_ok) begin
               e.err = 1'b1;
               e.br  = '0;
            end else e.br = model_mem[int'(idx)];
         end
         if (fwe || fre) begin
            if (ph != P_COMPUTE) e.err = 1'b1;
            else if (!core_ok) begin
               e.err = 1'b1;
               if (!fwe) e.fft = '0;
            end else if (fwe) model_mem[int'(faddr)] = fwdata;
            else e.fft = model_mem[int'(faddr)];
         end
         if (wr) begin
            if (!(ph == P_LOAD || ph == P_UNLOAD) || !br_ok) e.err = 1'b1;
            else begin
               model_mem[load_index(int'(idx))] = {sample, 16'h0000};
               if (ph == P_UNLOAD) begin
                  phase  = P_LOAD;
                  e.calc = 1'b0;
               end else if (loaded) begin
                  phase      = P_START;
                  start_wait = 1;
               end
            end
         end
         if (ph == P_START) begin
            if (start_wait == 1) begin
               e.start    = 1'b1;
               start_wait = 0;
            end else phase = P_COMPUTE;
         end
         if (ph == P_COMPUTE && fdone) begin
            phase  = P_UNLOAD;
            e.calc = 1'b1;
         end
      end
      cur = e;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      rstn   = 1'b1;
      wr     = 1'b0;
      rd     = 1'b0;
      loaded = 1'b0;
      fwe    = 1'b0;
      fre    = 1'b0;
      fdone  = 1'b0;
   endtask

   task automatic cycle();
      step();
      @(posedge clk);
      #2;
      idle();
   endtask

   task automatic br_write(input int i, input logic [15:0] s, input logic last);
      wr     = 1'b1;
      idx    = AW'(i);
      sample = s;
      loaded = last;
      cycle();
   endtask

   task automatic br_read(input int i);
      rd  = 1'b1;
      idx = AW'(i);
      cycle();
   endtask

   task automatic core_op(input int a, input logic we, input logic re, input logic [DW-1:0] d,
                          input logic done);
      faddr  = AW'(a);
      fwe    = we;
      fre    = re;
      fwdata = d;
      fdone  = done;
      cycle();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("access_err", 32'(acc_err), 32'(e.err));
         check("fft_start", 32'(fft_start), 32'(e.start));
         check("calc_end", 32'(calc_end), 32'(e.calc));
         check("bridge_rdata", br_data, e.br);
         check("core_rdata", frdata, e.fft);
      end
   end

   initial begin
      int n;
      int k;
      idle();
      n_samples = AW'(8);
      log2n     = 4'd3;
      sample    = '0;
      idx       = '0;
      faddr     = '0;
      fwdata    = '0;
      phase     = P_LOAD;
      start_wait = 0;
      cur       = '0;

      rstn = 1'b0; cycle();
      rstn = 1'b0; cycle();
      check("reset_calc_end", 32'(calc_end), 32'd0);
      check("reset_core_rdata", frdata, 32'd0);

      for (int i = 0; i < 3; i++) br_write(i, 16'(i + 100), 1'b0);
      rstn = 1'b0; cycle();
      check("midload_reset_calc_end", 32'(calc_end), 32'd0);
      check("midload_reset_rdata", frdata, 32'd0);

      for (int i = 0; i < 8; i++) br_write(i, 16'(i + 1), i == 7);
      check("start_low_t1", 32'(fft_start), 32'd0);
      cycle();
      check("start_pulse_t2", 32'(fft_start), 32'd1);
      cycle();
      check("start_low_t3", 32'(fft_start), 32'd0);
      core_op(3, 1'b0, 1'b1, '0, 1'b0);
      check("core_read_addr3", frdata, EXP_A3);

      br_write(1, 16'h5555, 1'b0);
      check("bridge_write_in_compute_err", 32'(acc_err), 32'd1);
      core_op(2, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
      check("we_re_rdata_holds", frdata, EXP_A3);
      core_op(5, 1'b1, 1'b0, 32'h1234_5678, 1'b1);
      check("calc_end_after_done", 32'(calc_end), 32'd1);

      core_op(0, 1'b0, 1'b1, '0, 1'b0);
      check("core_read_in_unload_err", 32'(acc_err), 32'd1);
      br_read(5);
      check("bridge_read_5", br_data, 32'h1234_5678);
      br_read(8);
      check("bridge_read_oor_zero", br_data, 32'd0);
      check("bridge_read_oor_err", 32'(acc_err), 32'd1);
      br_read(2);
      check("bridge_read_2", br_data, 32'hDEAD_BEEF);
      br_read(1);

      br_write(0, 16'hABCD, 1'b0);
      check("calc_end_falls", 32'(calc_end), 32'd0);
      for (int i = 1; i < 8; i++) br_write(i, 16'($urandom), i == 7);
      cycle();
      cycle();
      core_op(0, 1'b0, 1'b1, '0, 1'b0);
      check("word0_new_frame", frdata, 32'hABCD_0000);
      core_op(1, 1'b0, 1'b1, '0, 1'b1);

      for (int f = 0; f < 6; f++) begin
         n = int'(n_samples);
         repeat ($urandom_range(3, 8)) begin
            k = int'($urandom_range(0, 3));
            if (k == 0) core_op(int'($urandom_range(0, n - 1)), 1'b0, 1'b1, '0, 1'b0);
            else if (k == 1) cycle();
            else br_read(int'($urandom_range(0, n)));
         end
         k         = int'($urandom_range(1, 4));
         n         = 1 << k;
         n_samples = AW'(n);
         log2n     = 4'(k);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) br_read(i);
            if ($urandom_range(0, 3) == 0) cycle();
            br_write(i, 16'($urandom), i == n - 1);
         end
         cycle();
         cycle();
         repeat ($urandom_range(4, 10)) begin
            k = int'($urandom_range(0, 4));
            if (k == 0) br_read(int'($urandom_range(0, n - 1)));
            else core_op(int'($urandom_range(0, n)), 1'($urandom), 1'($urandom), $urandom, 1'b0);
         end
         core_op(int'($urandom_range(0, n - 1)), 1'b0, 1'b1, '0, 1'b1);
      end

      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_sample_store.md
# fft_sample_store

Sample memory between the AXI bridge and the FFT core. It accepts 16-bit real samples from the bridge's RAM port and stores them as 32-bit complex words. It hands the buffer to the FFT core for in-place computation, then serves results back to the bridge's read path. A phase state machine arbitrates single-port ownership and generates the bridge's calculation-end flag.

## Interface
Parameters:
- ADDR_WIDTH, 12: word address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32: stored word, {real[31:16], imag[15:0]}.

Ports:
- i_clk, in, 1: clock.
- i_rstn, in, 1: reset; one clock, synchronous, active-low.
- i_SAMPLE_ram, in, 16: bridge write sample.
- i_SAMPLE_INDEX_ram, in, ADDR_WIDTH: bridge word index.
- i_WRITE_ram, in, 1: bridge write strobe.
- i_READ_ram, in, 1: bridge read strobe.
- i_DATA_LOADED, in, 1: bridge flag; last sample being written.
- o_DATA_FROM_RAM, out, DATA_WIDTH: bridge read data.
- o_CALC_END, out, 1: results available to bridge.
- i_SAMPLES_NUMBER, in, ADDR_WIDTH: frame length N, 1..depth.
- i_LOG2N, in, 4: log2(N); used only with bit-reversal.
- o_FFT_START, out, 1: one-cycle start pulse to the FFT core.
- i_FFT_ADDR, in, ADDR_WIDTH: core word address.
- i_FFT_WE, in, 1: core write enable.
- i_FFT_RE, in, 1: core read enable.
- i_FFT_WDATA, in, DATA_WIDTH: core write data.
- o_FFT_RDATA, out, DATA_WIDTH: core read data.
- i_FFT_DONE, in, 1: core finished.
- o_ACCESS_ERR, out, 1: one-cycle pulse on a rejected access.

## Operation
- States: LOAD, START, COMPUTE, UNLOAD.

LOAD
- A bridge write stores {i_SAMPLE_ram, 16'h0000} at the mapped index.
- If i_DATA_LOADED is high in the same cycle as i_WRITE_ram, the write is committed and the next state is START.
- i_DATA_LOADED without i_WRITE_ram is ignored.

START
- o_FFT_START = 1 for exactly one cycle; next state is COMPUTE.

COMPUTE
- The core port owns the memory.
- i_FFT_WE writes i_FFT_WDATA.
- i_FFT_RE reads into o_FFT_RDATA.
- WE and RE together: the write wins and o_FFT_RDATA holds its value.
- i_FFT_DONE moves the state to UNLOAD. An access in the DONE cycle is still serviced.

UNLOAD
- o_CALC_END = 1.
- i_READ_ram reads into o_DATA_FROM_RAM.
- i_WRITE_ram starts a new frame: that write is committed as a LOAD write, and the next state is LOAD.

Rejected accesses (each pulses o_ACCESS_ERR; no memory change; read outputs hold):
- Bridge access in START or COMPUTE.
- Bridge read in LOAD.
- Core access outside COMPUTE.

Range rule:
- Any index ≥ i_SAMPLES_NUMBER is rejected with o_ACCESS_ERR.
- An out-of-range read drives its data output to 0.

Memory:
- Single inferred synchronous RAM with a registered read.
- Contents are not reset.

## Timing
- Read latency: 1 cycle. Address and strobe in cycle t give data valid in cycle t+1; the output holds until the next read.
- Write: committed at the clock edge of the strobe cycle.
- Transition latencies:
  - The LOAD→START edge is the cycle after the final write; o_FFT_START is high the following cycle.
  - Earliest core access: the cycle after o_FFT_START.
- o_CALC_END rises the cycle after i_FFT_DONE is sampled. It falls the cycle after the new-frame write.
- Reset (i_rstn low at an edge), including mid-frame:
  - state = LOAD.
  - o_CALC_END, o_FFT_START, o_ACCESS_ERR = 0.
  - o_DATA_FROM_RAM, o_FFT_RDATA = 0.
  - No write occurs in the reset cycle.

## Configuration
- FFT_STORE_BITREV_EN defined:
  - Bridge LOAD writes go to the address with the low i_LOG2N bits of the index bit-reversed. The core therefore receives decimation-in-time input order.
  - Upper bits are zero.
  - The range check uses the unreversed index.
  - Bridge reads are never reversed.
- Not defined: LOAD writes use the index unchanged; i_LOG2N is ignored.

## Test plan
- Reset mid-LOAD after 3 writes -> state LOAD; o_CALC_END=0, o_FFT_RDATA=0; a new load restarts cleanly.
- N=8: load samples 1..8, DATA_LOADED on index 7 -> o_FFT_START single pulse 2 cycles after the last write; core reads addr 3 -> o_FFT_RDATA=32'h0004_0000 next cycle (macro off) or 32'h0007_0000 (macro on).
- Core writes addr 5 = 32'h1234_5678, asserts DONE -> o_CALC_END next cycle; bridge reads index 5 -> 32'h1234_5678 one cycle later.
- Bridge write during COMPUTE, core read during UNLOAD, bridge read index 8 with N=8 -> three o_ACCESS_ERR pulses; memory unchanged; out-of-range read returns 0.
- Core WE+RE same cycle, addr 2 -> write committed; o_FFT_RDATA unchanged.
- In UNLOAD, bridge write index 0 = 16'hABCD -> next state LOAD; o_CALC_END falls; word 0 = 32'hABCD_0000.
